// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch path: field widths, opcodes
// and the {pc, instr} record carried from fetch towards decode.
package cpu_isa_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OPC_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;
    localparam logic [OPC_W-1:0] OP_TBD  = 5'b11111;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between ROM read and decode. The head is held in its
// own register, so a pushed word is never visible in the same cycle.
import cpu_isa_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = PC_W + INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      cnt_left;
    logic [AW:0]      cnt_nxt;
    logic             do_pop;

    // Next read pointer and occupancy after this cycle's pop/push.
    always_comb begin
        do_pop   = pop && (count != '0);
        rd_nxt   = rd_ptr + AW'(do_pop);
        cnt_left = count - (AW+1)'(do_pop);
        cnt_nxt  = cnt_left + (AW+1)'(push);
    end

    // Storage array; contents are qualified by count, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and the registered head; head holds when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            valid  <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                head <= (cnt_left == '0) ? din : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, ROM addressing, redirect and HALT handling.
// Define FETCH_STATS_EN to add the stall_cnt_o full-FIFO stall counter.
import cpu_isa_pkg::*;

module instr_fetch_unit #(
    parameter int                PC_W     = cpu_isa_pkg::PC_W,
    parameter int                INSTR_W  = cpu_isa_pkg::INSTR_W,
    parameter int                OPC_W    = cpu_isa_pkg::OPC_W,
    parameter int                DEPTH    = 2,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [OPC_W-1:0]  HALT_OPC = OP_HALT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_W-1:0]        rom_pc_o,
    input  logic [INSTR_W-1:0]     rom_instr_i,
    input  logic                   redirect_i,
    input  logic [PC_W-1:0]        redirect_pc_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [INSTR_W-1:0]     dec_instr_o,
    output logic [PC_W-1:0]        dec_pc_o,
    output logic                   halted_o,
`ifdef FETCH_STATS_EN
    output logic [31:0]            stall_cnt_o,
`endif
    output logic [$clog2(DEPTH):0] fifo_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        FETCH,
        HALTED
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            pop;
    logic            full;
    logic            push;
    logic            is_halt;

    assign rom_pc_o = pc;
    assign halted_o = (state == HALTED);
    assign pop      = dec_valid_o && dec_ready_i;
    assign full     = (fifo_cnt_o == CNT_W'(DEPTH));
    assign push     = (state == FETCH) && !redirect_i
                   && (!full || pop);
    assign is_halt  =
        (rom_instr_i[INSTR_W-1 -: OPC_W] == HALT_OPC);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({pc, rom_instr_i}),
        .head  ({dec_pc_o, dec_instr_o}),
        .valid (dec_valid_o),
        .count (fifo_cnt_o)
    );

    // PC and fetch state: redirect beats push, HALT parks the fetcher.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else if (redirect_i) begin
            state <= FETCH;
            pc    <= redirect_pc_i;
        end else if (push) begin
            pc <= pc + 1'b1;
            if (is_halt) begin
                state <= HALTED;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating count of cycles lost to a full FIFO while fetching.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if ((state == FETCH) && full && !pop
                     && !redirect_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, corner sequences and
// random traffic against a queue-based reference model.
import cpu_isa_pkg::*;

module tb_instr_fetch_unit;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [15:0] rom_pc;
    logic [8:0]  rom_instr;
    logic        redir;
    logic [15:0] rpc;
    logic        dvalid;
    logic        rdy;
    logic [8:0]  dinstr;
    logic [15:0] dpc;
    logic        halted;
    logic [1:0]  cnt;
`ifdef FETCH_STATS_EN
    logic [31:0] stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_pc_o      (rom_pc),
        .rom_instr_i   (rom_instr),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .dec_valid_o   (dvalid),
        .dec_ready_i   (rdy),
        .dec_instr_o   (dinstr),
        .dec_pc_o      (dpc),
        .halted_o      (halted),
`ifdef FETCH_STATS_EN
        .stall_cnt_o   (stall),
`endif
        .fifo_cnt_o    (cnt)
    );

    // ROM image: scrambled words, HALT only at address 43.
    function automatic logic [8:0] rom_word(input logic [15:0] a);
        logic [4:0] o;
        o = a[4:0] ^ a[9:5] ^ 5'h03;
        if (o == OP_HALT) o = 5'h01;
        if (a == 16'd43) o = OP_HALT;
        return {o, a[3:0] ^ a[15:12]};
    endfunction

    always_comb rom_instr = rom_word(rom_pc);

    // Reference model: a queue of fetched records plus PC and halt flag.
    fetch_entry_t q[$];
    logic [15:0]  m_pc;
    bit           m_halt;
    fetch_entry_t m_last;
    bit           m_live = 0;

    task automatic model_step();
        bit           pop;
        bit           psh;
        fetch_entry_t e;
        if (!rst_n) begin
            q.delete();
            m_pc   = 16'd0;
            m_halt = 0;
            m_last = '0;
            m_live = 1;
        end else if (m_live) begin
            if (redir) begin
                q.delete();
                m_pc   = rpc;
                m_halt = 0;
            end else begin
                pop = (q.size() > 0) && rdy;
                psh = !m_halt && (q.size() < 2 || pop);
                if (pop) void'(q.pop_front());
                if (psh) begin
                    e.pc    = m_pc;
                    e.instr = rom_word(m_pc);
                    q.push_back(e);
                    if (e.instr[8:4] == OP_HALT) m_halt = 1;
                    m_pc = m_pc + 16'd1;
                end
                if (q.size() > 0) m_last = q[0];
            end
        end
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic model_cmp();
        if (m_live) begin
            chk("m_rom_pc", 32'(rom_pc), 32'(m_pc));
            chk("m_valid", 32'(dvalid), 32'(q.size() > 0));
            chk("m_cnt", 32'(cnt), 32'(q.size()));
            chk("m_halted", 32'(halted), 32'(m_halt));
            chk("m_dec_pc", 32'(dpc), 32'(m_last.pc));
            chk("m_dec_instr", 32'(dinstr), 32'(m_last.instr));
        end
    endtask

    // Drive a cycle's inputs, then compare mid-cycle on the falling edge.
    task automatic cyc(input bit r, input bit rd,
                       input bit rdi, input logic [15:0] tp);
        rst_n = r;
        rdy   = rd;
        redir = rdi;
        rpc   = tp;
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rdi;
        logic [15:0] rpc;
        bit          c;
        logic [15:0] e_rom;
        bit          e_v;
        logic [15:0] e_dpc;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t v(bit r, bit rd, bit rdi,
                               logic [15:0] tp, bit c,
                               logic [15:0] er, bit ev,
                               logic [15:0] ed, logic [1:0] ec);
        vec_t t;
        t.rst = r;  t.rdy = rd; t.rdi = rdi; t.rpc = tp;
        t.c = c;    t.e_rom = er; t.e_v = ev;
        t.e_dpc = ed; t.e_cnt = ec;
        return t;
    endfunction

    vec_t tv[33];

    initial begin
        // reset then stream with ready=1
        tv[0]  = v(0,1,0,0,      0, 0,0,0,0);
        tv[1]  = v(1,1,0,0,      1, 0,0,0,0);
        tv[2]  = v(1,1,0,0,      1, 1,1,0,1);
        tv[3]  = v(1,1,0,0,      1, 2,1,1,1);
        tv[4]  = v(1,1,0,0,      1, 3,1,2,1);
        tv[5]  = v(1,1,0,0,      1, 4,1,3,1);
        // backpressure from reset, then release
        tv[6]  = v(0,0,0,0,      0, 0,0,0,0);
        tv[7]  = v(1,0,0,0,      1, 0,0,0,0);
        tv[8]  = v(1,0,0,0,      1, 1,1,0,1);
        tv[9]  = v(1,0,0,0,      1, 2,1,0,2);
        tv[10] = v(1,0,0,0,      1, 2,1,0,2);
        tv[11] = v(1,0,0,0,      1, 2,1,0,2);
        tv[12] = v(1,0,0,0,      1, 2,1,0,2);
        tv[13] = v(1,1,0,0,      1, 2,1,0,2);
        tv[14] = v(1,1,0,0,      1, 3,1,1,2);
        tv[15] = v(1,1,0,0,      1, 4,1,2,2);
        tv[16] = v(1,1,0,0,      1, 5,1,3,2);
        // redirect with a full FIFO
        tv[17] = v(0,0,0,0,      0, 0,0,0,0);
        tv[18] = v(1,0,0,0,      1, 0,0,0,0);
        tv[19] = v(1,0,0,0,      1, 1,1,0,1);
        tv[20] = v(1,0,1,27,     1, 2,1,0,2);
        tv[21] = v(1,1,0,0,      1, 27,0,0,0);
        tv[22] = v(1,1,0,0,      1, 28,1,27,1);
        tv[23] = v(1,1,0,0,      1, 29,1,28,1);
        // reset beats redirect mid-stream
        tv[24] = v(1,0,0,0,      1, 30,1,29,1);
        tv[25] = v(0,0,1,500,    1, 31,1,29,2);
        tv[26] = v(1,1,0,0,      1, 0,0,0,0);
        tv[27] = v(1,1,0,0,      1, 1,1,0,1);
        // PC wrap through 16'hFFFF
        tv[28] = v(1,1,1,16'hFFFE, 1, 2,1,1,1);
        tv[29] = v(1,1,0,0,      1, 16'hFFFE,0,1,0);
        tv[30] = v(1,1,0,0,      1, 16'hFFFF,1,16'hFFFE,1);
        tv[31] = v(1,1,0,0,      1, 0,1,16'hFFFF,1);
        tv[32] = v(1,1,0,0,      1, 1,1,0,1);

        for (int i = 0; i < 33; i++) begin
            cyc(tv[i].rst, tv[i].rdy, tv[i].rdi, tv[i].rpc);
            if (tv[i].c) begin
                chk("tv_rom_pc", 32'(rom_pc), 32'(tv[i].e_rom));
                chk("tv_valid", 32'(dvalid), 32'(tv[i].e_v));
                chk("tv_cnt", 32'(cnt), 32'(tv[i].e_cnt));
                chk("tv_dec_pc", 32'(dpc), 32'(tv[i].e_dpc));
                chk("tv_halted", 32'(halted), 32'd0);
                if (tv[i].e_v)
                    chk("tv_instr", 32'(dinstr),
                        32'(rom_word(tv[i].e_dpc)));
            end
`ifdef FETCH_STATS_EN
            if (i == 13) chk("stall_cnt", stall, 32'd4);
`endif
            adv();
        end

        // HALT at 43, then release with a redirect to 1
        cyc(1,1,1,16'd41); adv();
        cyc(1,1,0,0); chk("h_rom41", 32'(rom_pc), 32'd41);
        adv();
        cyc(1,1,0,0); chk("h_dpc41", 32'(dpc), 32'd41);
        adv();
        cyc(1,1,0,0); chk("h_rom43", 32'(rom_pc), 32'd43);
        adv();
        cyc(1,1,0,0);
        chk("h_dpc43", 32'(dpc), 32'd43);
        chk("h_opc", 32'(dinstr[8:4]), 32'(OP_HALT));
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_rom44", 32'(rom_pc), 32'd44);
        adv();
        for (int k = 0; k < 3; k++) begin
            cyc(1,1,0,0);
            chk("h_park_rom", 32'(rom_pc), 32'd44);
            chk("h_park_v", 32'(dvalid), 32'd0);
            chk("h_park_hlt", 32'(halted), 32'd1);
            adv();
        end
        cyc(1,1,1,16'd1); adv();
        cyc(1,1,0,0);
        chk("h_clr", 32'(halted), 32'd0);
        chk("h_rom1", 32'(rom_pc), 32'd1);
        adv();
        cyc(1,1,0,0); chk("h_dpc1", 32'(dpc), 32'd1);
        adv();

        // redirect in the same cycle as a pop
        cyc(1,1,1,16'd200);
        chk("rp_pop_v", 32'(dvalid), 32'd1);
        adv();
        cyc(1,1,0,0); chk("rp_v0", 32'(dvalid), 32'd0);
        adv();
        cyc(1,1,0,0); chk("rp_dpc", 32'(dpc), 32'd200);
        adv();

        // redirect in the cycle HALT would be pushed
        cyc(1,1,1,16'd41); adv();
        cyc(1,1,0,0); adv();
        cyc(1,1,0,0); adv();
        cyc(1,1,1,16'd100);
        chk("rh_rom43", 32'(rom_pc), 32'd43);
        adv();
        cyc(1,1,0,0);
        chk("rh_hlt", 32'(halted), 32'd0);
        chk("rh_rom", 32'(rom_pc), 32'd100);
        adv();
        cyc(1,1,0,0);
        chk("rh_dpc", 32'(dpc), 32'd100);
        chk("rh_hlt2", 32'(halted), 32'd0);
        adv();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] tp;
            case ($urandom_range(0, 3))
                0: tp = 16'hFFFC + 16'($urandom_range(0, 3));
                1: tp = 16'd38 + 16'($urandom_range(0, 6));
                2: tp = 16'($urandom);
                default: tp = 16'($urandom_range(0, 50));
            endcase
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 15) == 0, tp);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
